// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command bytes, controller/phy state encodings and init-sequence helpers
package lcd_pkg;
  localparam logic [7:0] FUNC_SET   = 8'h38;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] ENTRY_MODE = 8'h06;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] LINE1      = 8'h80;
  localparam logic [7:0] LINE2      = 8'hC0;
  localparam int INIT_LEN = 4;
  typedef enum logic [2:0] {ST_PWR_WAIT, ST_INIT, ST_LINE, ST_CHAR, ST_FINISH, ST_IDLE} state_t;
  typedef enum logic [1:0] {PH_IDLE, PH_PULSE, PH_WAIT} phase_t;
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    return idx == 2'd0 ? FUNC_SET : idx == 2'd1 ? DISP_ON : idx == 2'd2 ? ENTRY_MODE : CLEAR;
  endfunction
  function automatic int max3(input int a, input int b, input int c);
    return (a > b ? a : b) > c ? (a > b ? a : b) : c;
  endfunction
endpackage

// File: rtl/lcd_write_phy.sv
// lcd_write_phy: single LCD byte write -- setup, enable pulse, then post-write wait
module lcd_write_phy
  import lcd_pkg::*;
#(
  parameter int E_PULSE_CYC  = 24,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 82000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  input  logic       i_long,
  output logic       o_e,
  output logic       o_rs,
  output logic [7:0] o_data,
  output logic       o_ready
);
  localparam int CW = $clog2(max3(E_PULSE_CYC, CMD_WAIT_CYC, CLR_WAIT_CYC) + 1);
  phase_t        r_phase;
  logic [CW-1:0] r_cnt;
  logic          r_rs;
  logic [7:0]    r_data;
  logic          r_long;
  logic [CW-1:0] w_lim;
  logic          w_last;
  logic          w_setup;
  assign w_setup = i_start && r_phase == PH_IDLE;
  assign w_lim   = r_phase == PH_PULSE ? CW'(E_PULSE_CYC - 1) : r_long ? CW'(CLR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
  assign w_last  = r_cnt == w_lim;
  // the setup cycle shows the new byte on the bus (e low) and latches it for the pulse and wait
  assign o_rs    = w_setup ? i_rs : r_rs;
  assign o_data  = w_setup ? i_data : r_data;
  assign o_e     = r_phase == PH_PULSE;
  assign o_ready = r_phase == PH_WAIT && w_last;
  // phase sequencing: latch byte on start, count pulse then wait length
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_phase <= PH_IDLE;
      r_cnt   <= '0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
      r_long  <= 1'b0;
    end else if (w_setup) begin
      r_phase <= PH_PULSE;
      r_cnt   <= '0;
      r_rs    <= i_rs;
      r_data  <= i_data;
      r_long  <= i_long;
    end else if (r_phase != PH_IDLE) begin
      r_cnt <= w_last ? '0 : r_cnt + CW'(1);
      if (w_last) r_phase <= r_phase == PH_PULSE ? PH_WAIT : PH_IDLE;
    end
  end
endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 init plus 2x16 character redraw sequencer driving the LCD pins
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int E_PULSE_CYC  = 24,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 82000,
  parameter int PWR_WAIT_CYC = 750000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       refresh,
  output logic [4:0] char_addr,
  input  logic [7:0] char_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       done
);
  localparam int PCW = $clog2(PWR_WAIT_CYC + 1);
  state_t         r_state, w_nstate;
  logic [PCW-1:0] r_pcnt, w_pcnt_nxt;
  logic [1:0]     r_idx, w_idx_nxt;
  logic [4:0]     r_addr, w_addr_nxt;
  logic           r_sent, w_sent_nxt;
  logic           r_pend, w_pend_nxt;
  logic           w_start, w_rs, w_long, w_ready;
  logic [7:0]     w_data;
  assign char_addr = r_addr;
  assign busy      = r_state != ST_IDLE;
  assign lcd_rw    = 1'b0;
  lcd_write_phy #(
    .E_PULSE_CYC (E_PULSE_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC),
    .CLR_WAIT_CYC(CLR_WAIT_CYC)
  ) u_phy (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(w_start),
    .i_rs   (w_rs),
    .i_data (w_data),
    .i_long (w_long),
    .o_e    (lcd_e),
    .o_rs   (lcd_rs),
    .o_data (lcd_data),
    .o_ready(w_ready)
  );
  // sequencer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_PWR_WAIT;
      r_pcnt  <= '0;
      r_idx   <= 2'd0;
      r_addr  <= 5'd0;
      r_sent  <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_pcnt  <= w_pcnt_nxt;
      r_idx   <= w_idx_nxt;
      r_addr  <= w_addr_nxt;
      r_sent  <= w_sent_nxt;
      r_pend  <= w_pend_nxt;
    end
  end
  // each byte state issues one write, then advances when the phy reports its wait is over
  always_comb begin
    w_nstate   = r_state;
    w_pcnt_nxt = r_pcnt;
    w_idx_nxt  = r_idx;
    w_addr_nxt = r_addr;
    w_pend_nxt = r_pend || (refresh && r_state != ST_IDLE);
    w_start    = 1'b0;
    w_rs       = 1'b0;
    w_data     = 8'h00;
    done       = 1'b0;
    case (r_state)
      ST_PWR_WAIT: begin
        w_pcnt_nxt = r_pcnt + PCW'(1);
        if (r_pcnt == PCW'(PWR_WAIT_CYC - 1)) w_nstate = ST_INIT;
      end
      ST_INIT: begin
        w_start = !r_sent;
        w_data  = init_cmd(r_idx);
        if (w_ready) begin
          w_idx_nxt = r_idx + 2'd1;
          if (r_idx == 2'(INIT_LEN - 1)) w_nstate = ST_LINE;
        end
      end
      ST_LINE: begin
        w_start = !r_sent;
        w_data  = r_addr[4] ? LINE2 : LINE1;
        if (w_ready) w_nstate = ST_CHAR;
      end
      ST_CHAR: begin
        w_start = !r_sent;
        w_rs    = 1'b1;
        w_data  = char_data;
        if (w_ready) begin
          w_addr_nxt = r_addr == 5'd31 ? r_addr : r_addr + 5'd1;
          w_nstate   = r_addr == 5'd31 ? ST_FINISH : r_addr == 5'd15 ? ST_LINE : ST_CHAR;
        end
      end
      ST_FINISH: begin
        done       = 1'b1;
        w_addr_nxt = 5'd0;
        w_pend_nxt = 1'b0;
        w_nstate   = (r_pend || refresh) ? ST_LINE : ST_IDLE;
      end
      ST_IDLE: w_nstate = refresh ? ST_LINE : ST_IDLE;
      default: w_nstate = ST_PWR_WAIT;
    endcase
    w_long     = !w_rs && w_data == CLEAR;
    w_sent_nxt = w_ready ? 1'b0 : (r_sent || w_start);
  end
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed checks of init, draw, refresh and reset behaviour with a bus timing monitor
module tb_lcd_ctrl;
  localparam int E = 2, CMD = 3, CLR = 6, PWR = 10;
  logic       clk = 1'b0;
  logic       rst_n, refresh;
  logic [4:0] char_addr;
  logic [7:0] char_data;
  logic       lcd_rs, lcd_rw, lcd_e, busy, done;
  logic [7:0] lcd_data;
  int n_tests = 0, n_fail = 0;
  int m_bad = 0, m_idle = 0, m_done = 0;
  bit         wr_rs[$];
  logic [7:0] wr_data[$];
  int         wr_gap[$];
  typedef struct {
    string      nm;
    int         idx;
    bit         rs;
    logic [7:0] data;
    int         gap;
  } vec_t;
  vec_t tbl[10];
  always #5 clk = ~clk;
  assign char_data = 8'h40 + {3'b000, char_addr};
  lcd_ctrl #(.E_PULSE_CYC(E), .CMD_WAIT_CYC(CMD), .CLR_WAIT_CYC(CLR), .PWR_WAIT_CYC(PWR)) dut (
    .clk(clk), .rst_n(rst_n), .refresh(refresh), .char_addr(char_addr), .char_data(char_data),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_data(lcd_data), .busy(busy), .done(done)
  );
  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic wait_idle(input string nm);
    int k = 0;
    while (busy !== 1'b0 && k < 3000) begin
      @(posedge clk); #1;
      k++;
    end
    chk({nm, "_reaches_idle"}, busy, 0);
  endtask
  task automatic pulse_refresh();
    refresh = 1'b1;
    @(posedge clk); #1;
    refresh = 1'b0;
  endtask
  task automatic chk_draw(input int base, input string nm);
    int bad = 0;
    if (wr_data[base] !== 8'h80 || wr_rs[base] !== 1'b0) bad++;
    if (wr_data[base+17] !== 8'hC0 || wr_rs[base+17] !== 1'b0) bad++;
    for (int i = 0; i < 32; i++) begin
      int idx = base + 1 + i + (i >= 16 ? 1 : 0);
      if (wr_rs[idx] !== 1'b1 || wr_data[idx] !== 8'(8'h40 + i)) bad++;
    end
    chk(nm, bad, 0);
  endtask
  // bus monitor: logs every write and checks pulse width, setup and hold across the wait
  initial begin
    logic       p_e, p_rs, c_rs;
    logic [7:0] p_d, c_d;
    int         hi, low, wlen;
    bit         stab;
    p_e = 0; p_rs = 0; p_d = 0; c_rs = 0; c_d = 0; hi = 0; low = 0; wlen = 0; stab = 1;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        p_e = 0; hi = 0; low = 0; wlen = 0;
      end else begin
        if (lcd_rw !== 1'b0) begin
          m_bad++;
          $display("FAIL lcd_rw: got %b, expected 0", lcd_rw);
        end
        if (busy === 1'b0) m_idle++;
        if (done === 1'b1) m_done++;
        if (lcd_e && !p_e) begin
          wr_rs.push_back(lcd_rs);
          wr_data.push_back(lcd_data);
          wr_gap.push_back(low);
          c_rs = lcd_rs; c_d = lcd_data;
          stab = (p_rs === lcd_rs) && (p_d === lcd_data);
          hi = 1;
        end else if (lcd_e) begin
          hi++;
          if (lcd_rs !== c_rs || lcd_data !== c_d) stab = 0;
        end else begin
          if (p_e) begin
            if (hi != E) begin
              m_bad++;
              $display("FAIL e_width: got %0d cycles, expected %0d", hi, E);
            end
            wlen = (!c_rs && c_d == 8'h01) ? CLR : CMD;
            low = 0;
          end
          low++;
          if (low <= wlen) begin
            if (lcd_rs !== c_rs || lcd_data !== c_d) stab = 0;
            if (low == wlen && !stab) begin
              m_bad++;
              $display("FAIL bus_hold: byte 0x%0h rs %b not held from setup to wait end", c_d, c_rs);
            end
          end
        end
        p_e = lcd_e; p_rs = lcd_rs; p_d = lcd_data;
      end
    end
  end
  initial begin
    int n, base, d0, i0;
    bit found;
    tbl[0] = '{"func_set", 0, 1'b0, 8'h38, -1};
    tbl[1] = '{"disp_on", 1, 1'b0, 8'h0C, 4};
    tbl[2] = '{"entry_mode", 2, 1'b0, 8'h06, 4};
    tbl[3] = '{"clear", 3, 1'b0, 8'h01, 4};
    tbl[4] = '{"line1", 4, 1'b0, 8'h80, 7};
    tbl[5] = '{"char0", 5, 1'b1, 8'h40, 4};
    tbl[6] = '{"char15", 20, 1'b1, 8'h4F, 4};
    tbl[7] = '{"line2", 21, 1'b0, 8'hC0, 4};
    tbl[8] = '{"char16", 22, 1'b1, 8'h50, 4};
    tbl[9] = '{"char31", 37, 1'b1, 8'h5F, 4};
    rst_n = 1'b0; refresh = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_e", lcd_e, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_data", lcd_data, 0);
    chk("rst_addr", char_addr, 0);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = wr_data.size(); d0 = m_done; i0 = m_idle;
    n = 0;
    while (!lcd_e && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("first_e_rise_cycles", n, PWR + 1);
    chk("first_e_rs", lcd_rs, 0);
    chk("first_e_data", lcd_data, 8'h38);
    wait_idle("powerup_draw");
    chk("powerup_write_count", wr_data.size() - base, 38);
    chk("powerup_done_pulses", m_done - d0, 1);
    chk("powerup_busy_held", m_idle - i0, 0);
    chk("powerup_end_addr", char_addr, 0);
    for (int i = 0; i < 10; i++) begin
      chk({tbl[i].nm, "_rs"}, wr_rs[base+tbl[i].idx], tbl[i].rs);
      chk({tbl[i].nm, "_data"}, wr_data[base+tbl[i].idx], tbl[i].data);
      if (tbl[i].gap >= 0) chk({tbl[i].nm, "_gap"}, wr_gap[base+tbl[i].idx], tbl[i].gap);
    end
    chk_draw(base + 4, "powerup_sequence");
    repeat (5) @(posedge clk);
    #1;
    chk("idle_busy_low", busy, 0);
    base = wr_data.size(); d0 = m_done;
    pulse_refresh();
    chk("refresh_busy_next_cycle", busy, 1);
    wait_idle("refresh_draw");
    chk("refresh_write_count", wr_data.size() - base, 34);
    chk_draw(base, "refresh_sequence");
    chk("refresh_done_pulses", m_done - d0, 1);
    base = wr_data.size(); d0 = m_done;
    pulse_refresh();
    i0 = m_idle;
    repeat (20) @(posedge clk);
    #1;
    pulse_refresh();
    repeat (30) @(posedge clk);
    #1;
    pulse_refresh();
    repeat (40) @(posedge clk);
    #1;
    pulse_refresh();
    wait_idle("pending_draws");
    chk("pending_done_pulses", m_done - d0, 2);
    chk("pending_no_idle_gap", m_idle - i0, 0);
    chk("pending_write_count", wr_data.size() - base, 68);
    chk_draw(base, "pending_first_draw");
    chk_draw(base + 34, "pending_second_draw");
    chk("pending_restart_gap", wr_gap[base+34], CMD + 2);
    repeat (100) @(posedge clk);
    #1;
    chk("pending_no_third_draw", m_done - d0, 2);
    chk("pending_settles_idle", busy, 0);
    pulse_refresh();
    n = 0; found = 0;
    while (!found && n < 1000) begin
      @(posedge clk); #1;
      found = (char_addr == 5'd20) && lcd_e;
      n++;
    end
    chk("reach_char20_pulse", found, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_e", lcd_e, 0);
    chk("midrst_addr", char_addr, 0);
    chk("midrst_busy", busy, 1);
    chk("midrst_data", lcd_data, 0);
    base = wr_data.size(); d0 = m_done;
    rst_n = 1'b1;
    wait_idle("reinit_draw");
    chk("reinit_write_count", wr_data.size() - base, 38);
    for (int i = 0; i < 4; i++) chk("reinit_cmd", wr_data[base+i], tbl[i].data);
    chk_draw(base + 4, "reinit_sequence");
    chk("reinit_done_pulses", m_done - d0, 1);
    chk("timing_violations", m_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
